// File: rtl/router_pkg.sv
// ============================================================================
// Module      : router_pkg
// Description : Shared widths and flit type for the router input-port FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 2;
  localparam int OBUF_D = 2;
  // Occupancy covers DEPTH + OBUF_D = 6 flits.
  localparam int OCC_W  = 3;

  typedef logic [DATA_W-1:0] flit_t;

endpackage : router_pkg

`default_nettype wire

// File: rtl/router_ram_fifo_ctrl_if.sv
// ============================================================================
// Module      : router_ram_fifo_ctrl_if
// Description : Flit in/out handshakes plus RAM port bundle for the FIFO ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface router_ram_fifo_ctrl_if;
  import router_pkg::*;

  logic              in_valid;
  logic              in_ready;
  flit_t             in_data;
  logic              out_valid;
  logic              out_ready;
  flit_t             out_data;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  flit_t             mem_wr_data;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  flit_t             mem_rd_data;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    input  in_valid, in_data, out_ready, mem_rd_data,
    output in_ready, out_valid, out_data,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output mem_rd_en, mem_rd_addr, occupancy
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_rd_data,
    input  in_ready, out_valid, out_data,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  mem_rd_en, mem_rd_addr, occupancy
  );

endinterface : router_ram_fifo_ctrl_if

`default_nettype wire

// File: rtl/router_fifo_obuf.sv
// ============================================================================
// Module      : router_fifo_obuf
// Description : Small push/pop output buffer with registered head and count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_fifo_obuf #(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int DEPTH  = router_pkg::OBUF_D,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  rd_idx;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= push_data;
        wr_idx      <= bump(wr_idx);
      end
      if (do_pop) begin
        rd_idx <= bump(rd_idx);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_idx];

endmodule : router_fifo_obuf

`default_nettype wire

// File: rtl/router_ram_fifo_ctrl.sv
// ============================================================================
// Module      : router_ram_fifo_ctrl
// Description : FIFO controller in front of a 4x64 RAM with 2-cycle read
//               latency; credit-gated reads land in a small output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module router_ram_fifo_ctrl #(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int ADDR_W = router_pkg::ADDR_W,
  parameter int DEPTH  = router_pkg::DEPTH,
  parameter int RD_LAT = router_pkg::RD_LAT,
  parameter int OBUF_D = router_pkg::OBUF_D
) (
  input  logic                   clk,
  input  logic                   rst_n,
  router_ram_fifo_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int INF_W = $clog2(RD_LAT + 1);
  localparam int OBC_W = $clog2(OBUF_D + 1);
  localparam int OCC_W = router_pkg::OCC_W;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  ram_cnt;
  logic [RD_LAT-1:0] vld_sr;
  logic [INF_W-1:0]  inflight;
  logic [OBC_W-1:0]  obuf_cnt;
  logic [OCC_W-1:0]  occ;
  logic              wr_go;
  logic              rd_go;
  logic              pop;
  logic              credit_ok;
  logic              obuf_valid;
  logic [DATA_W-1:0] obuf_data;

  assign bus.in_ready = rst_n && (ram_cnt != CNT_W'(DEPTH));
  assign wr_go        = bus.in_valid && bus.in_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + INF_W'(vld_sr[i]);
    end
  end

  // Every issued read must have a guaranteed output-buffer slot when it lands.
  assign credit_ok = (32'(inflight) + 32'(obuf_cnt)) < 32'(OBUF_D);
  assign rd_go     = (ram_cnt != '0) && credit_ok;
  assign pop       = obuf_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      occ     <= '0;
    end else begin
      if (wr_go) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_go) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({wr_go, rd_go})
        2'b10:   ram_cnt <= ram_cnt + CNT_W'(1);
        2'b01:   ram_cnt <= ram_cnt - CNT_W'(1);
        default: ram_cnt <= ram_cnt;
      endcase
      occ <= occ + OCC_W'(wr_go) - OCC_W'(pop);
    end
  end

  generate
    if (RD_LAT == 1) begin : g_sr_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_sr <= '0;
        end else begin
          vld_sr <= rd_go;
        end
      end
    end else begin : g_sr_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_sr <= '0;
        end else begin
          vld_sr <= {vld_sr[RD_LAT-2:0], rd_go};
        end
      end
    end
  endgenerate

  // Idle RAM ports are parked at zero so addresses/data only move on a real access.
  always_comb begin
    bus.mem_wr_en   = wr_go;
    bus.mem_wr_addr = wr_go ? wr_ptr : '0;
    bus.mem_wr_data = wr_go ? bus.in_data : '0;
    bus.mem_rd_en   = rd_go;
    bus.mem_rd_addr = rd_go ? rd_ptr : '0;
  end

  router_fifo_obuf #(
    .DATA_W (DATA_W),
    .DEPTH  (OBUF_D)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_sr[RD_LAT-1]),
    .push_data (bus.mem_rd_data),
    .pop       (pop),
    .out_valid (obuf_valid),
    .out_data  (obuf_data),
    .count     (obuf_cnt)
  );

  assign bus.out_valid = obuf_valid;
  assign bus.out_data  = obuf_data;
  assign bus.occupancy = occ;

endmodule : router_ram_fifo_ctrl

`default_nettype wire

// File: tb/tb_router_ram_fifo_ctrl.sv
// ============================================================================
// Module      : tb_router_ram_fifo_ctrl
// Description : Directed and random bench for router_ram_fifo_ctrl with a
//               behavioural 4x64, 2-cycle-latency RAM on the mem_* ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_router_ram_fifo_ctrl;
  import router_pkg::*;

  logic clk;
  logic rst_n;

  router_ram_fifo_ctrl_if bus ();

  router_ram_fifo_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Behavioural stand-in for mem_16nm_ram4x64: sync write, 2-stage read pipe.
  flit_t ram_arr [DEPTH];
  flit_t rd_stage;
  flit_t rd_q;

  always_ff @(posedge clk) begin
    if (bus.mem_wr_en) begin
      ram_arr[bus.mem_wr_addr] <= bus.mem_wr_data;
    end
    rd_stage <= ram_arr[bus.mem_rd_addr];
    rd_q     <= rd_stage;
  end

  assign bus.mem_rd_data = rd_q;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    n_checks;
  int    n_errors;
  int    n_wr;
  int    n_rd;
  int    n_pop;
  bit    acc;
  flit_t exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample one cycle at the falling edge and update the reference queue.
  task automatic observe();
    @(negedge clk);
    check("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
    if (exp_q.size() == 0) check("out_valid_empty", 64'(bus.out_valid), 64'(0));
    acc = bus.in_valid && bus.in_ready;
    if (bus.mem_wr_en) begin
      check("wr_addr", 64'(bus.mem_wr_addr), 64'(n_wr % DEPTH));
      check("wr_data", bus.mem_wr_data, bus.in_data);
      n_wr++;
    end
    if (bus.mem_rd_en) begin
      check("rd_addr", 64'(bus.mem_rd_addr), 64'(n_rd % DEPTH));
      n_rd++;
    end
    if (bus.out_valid && bus.out_ready) begin
      n_pop++;
      if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q.pop_front());
    end
    if (acc) exp_q.push_back(bus.in_data);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int    sent;
    int    rd0;
    int    pop0;
    int    extra;
    flit_t next_data;

    n_checks = 0; n_errors = 0; n_wr = 0; n_rd = 0; n_pop = 0; acc = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(bus.in_ready),  64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data",  bus.out_data,       64'(0));
    check("rst_wr_en",     64'(bus.mem_wr_en), 64'(0));
    check("rst_rd_en",     64'(bus.mem_rd_en), 64'(0));
    check("rst_rd_addr",   64'(bus.mem_rd_addr), 64'(0));
    check("rst_occ",       64'(bus.occupancy), 64'(0));
    rst_n = 1'b1;
    advance();

    // Single flit: write at cycle 0, read issue at 1, out_valid at 4
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 64'hA5;
    observe();
    check("t1_c0_in_ready", 64'(bus.in_ready),  64'(1));
    check("t1_c0_wr_en",    64'(bus.mem_wr_en), 64'(1));
    check("t1_c0_rd_en",    64'(bus.mem_rd_en), 64'(0));
    advance();
    bus.in_valid = 1'b0;
    observe();
    check("t1_c1_rd_en", 64'(bus.mem_rd_en), 64'(1));
    check("t1_c1_occ",   64'(bus.occupancy), 64'(1));
    advance();
    for (int c = 2; c < 4; c++) begin
      observe();
      check("t1_early_out", 64'(bus.out_valid), 64'(0));
      advance();
    end
    observe();
    check("t1_c4_out_valid", 64'(bus.out_valid), 64'(1));
    check("t1_c4_out_data",  bus.out_data,       64'hA5);
    advance();
    observe();
    check("t1_c5_occ", 64'(bus.occupancy), 64'(0));
    advance();

    // Stream 1..8; pointers start at 1 and wrap twice
    sent = 0;
    rd0  = n_rd;
    for (int c = 0; c < 80 && (sent < 8 || exp_q.size() != 0); c++) begin
      bus.in_valid = (sent < 8);
      bus.in_data  = 64'(sent + 1);
      observe();
      if (acc) sent++;
      advance();
    end
    bus.in_valid = 1'b0;
    check("s_sent",    64'(sent),         64'(8));
    check("s_reads",   64'(n_rd - rd0),   64'(8));
    check("s_drained", 64'(exp_q.size()), 64'(0));

    // Back-pressure: 10 offers, only 6 fit, two reads issued
    bus.out_ready = 1'b0;
    sent = 0;
    rd0  = n_rd;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 64'hB1 + 64'(sent);
      observe();
      if (c == 5) check("bp_in_ready_6th", 64'(bus.in_ready), 64'(1));
      if (c == 6) check("bp_in_ready_7th", 64'(bus.in_ready), 64'(0));
      if (acc) sent++;
      advance();
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", 64'(sent),       64'(6));
    check("bp_reads",    64'(n_rd - rd0), 64'(2));
    observe();
    check("bp_occ", 64'(bus.occupancy), 64'(6));
    advance();

    // Release with RAM full: read issue cycle keeps in_ready low, next cycle frees it
    bus.out_ready = 1'b1;
    pop0  = n_pop;
    extra = 0;
    for (int c = 0; c < 60 && (exp_q.size() != 0 || extra < 2); c++) begin
      bus.in_valid = (extra < 2);
      bus.in_data  = 64'hE0 + 64'(extra);
      observe();
      if (c == 0) begin
        check("full_c0_in_ready", 64'(bus.in_ready),  64'(0));
        check("full_c0_rd_en",    64'(bus.mem_rd_en), 64'(0));
      end
      if (c == 1) begin
        check("full_c1_rd_en",    64'(bus.mem_rd_en), 64'(1));
        check("full_c1_in_ready", 64'(bus.in_ready),  64'(0));
      end
      if (c == 2) check("full_c2_in_ready", 64'(bus.in_ready), 64'(1));
      if (acc) extra++;
      advance();
    end
    bus.in_valid = 1'b0;
    check("full_pops",    64'(n_pop - pop0),  64'(8));
    check("full_drained", 64'(exp_q.size()),  64'(0));

    // Reset with two reads in flight
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = (c < 2);
      bus.in_data  = 64'hD0 + 64'(c);
      observe();
      advance();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", 64'(bus.out_valid), 64'(0));
    check("mr_occ",       64'(bus.occupancy), 64'(0));
    check("mr_in_ready",  64'(bus.in_ready),  64'(0));
    exp_q.delete();
    n_wr = 0;
    n_rd = 0;
    for (int c = 0; c < 3; c++) begin
      observe();
      advance();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      observe();
      advance();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 64'hC3;
    observe();
    advance();
    bus.in_valid = 1'b0;
    for (int c = 1; c < 5; c++) begin
      observe();
      if (c < 4) check("mr_early_out", 64'(bus.out_valid), 64'(0));
      if (c == 4) begin
        check("mr_c3_valid", 64'(bus.out_valid), 64'(1));
        check("mr_c3_data",  bus.out_data,       64'hC3);
      end
      advance();
    end

    // Random valid/ready against the reference queue
    sent      = 0;
    pop0      = n_pop;
    next_data = {$urandom, $urandom};
    for (int c = 0; c < 60000 && (sent < 10000 || exp_q.size() != 0); c++) begin
      bus.in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      bus.in_data   = next_data;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      observe();
      if (acc) begin
        sent++;
        next_data = {$urandom, $urandom};
      end
      advance();
    end
    bus.in_valid = 1'b0;
    check("rand_sent",    64'(sent),          64'(10000));
    check("rand_popped",  64'(n_pop - pop0),  64'(10000));
    check("rand_drained", 64'(exp_q.size()),  64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_router_ram_fifo_ctrl

`default_nettype wire
